btc_nonce_scheduler: RTL and testbench
======================================

BTC_NONCE_SCHEDULER -- requirements
Module: btc_nonce_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of hash cores served; legal range 2..8.
REQ-002 SHALL have parameter CHUNK_LOG2, default 8: the nominal chunk is 2^CHUNK_LOG2 nonces.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port wb_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cfg_start, input, 1 bit: one-cycle pulse that starts a search.
REQ-006 SHALL have port cfg_stop, input, 1 bit: one-cycle pulse that aborts a search.
REQ-007 SHALL have ports cfg_nonce_lo and cfg_nonce_hi, inputs, 32 bits each: the inclusive nonce range, sampled on an accepted cfg_start.
REQ-008 SHALL have port core_req, input, NUM_CORES bits: level signal meaning the core is idle and wants work.
REQ-009 SHALL have port core_busy, input, NUM_CORES bits: the core is hashing.
REQ-010 SHALL have port core_found, input, NUM_CORES bits: one-cycle pulse meaning the core hit the target.
REQ-011 SHALL have port core_found_nonce, input, NUM_CORES*32 bits: the nonce reported by core i, in slice [32i+31:32i].
REQ-012 SHALL have port core_grant, output, NUM_CORES bits: one-hot, one-cycle grant.
REQ-013 SHALL have port core_base, output, 32 bits: first nonce of the granted chunk.
REQ-014 SHALL have port core_len, output, CHUNK_LOG2+1 bits: nonce count of the granted chunk.
REQ-015 SHALL have port busy, output, 1 bit: high while the state is not IDLE or DONE.
REQ-016 SHALL have port done, output, 1 bit: high in state DONE.
REQ-017 SHALL have port found, output, 1 bit: a hit has been latched.
REQ-018 SHALL have port found_nonce, output, 32 bits: the latched hit nonce.
REQ-019 SHALL have port found_core, output, 3 bits: index of the core that reported the hit.
REQ-020 SHALL have port irq, output, 1 bit: one-cycle pulse on entry to DONE.

Function
REQ-021 SHALL implement the states IDLE, DISPATCH, DRAIN and DONE.
REQ-022 IDLE/DONE + cfg_start: SHALL load next=cfg_nonce_lo and last=cfg_nonce_hi, clear found, found_nonce and found_core, and go to DISPATCH; if cfg_nonce_hi < cfg_nonce_lo it SHALL instead go directly to DONE.
REQ-023 SHALL ignore cfg_start while busy=1.
REQ-024 DISPATCH: SHALL issue at most one grant per cycle, chosen round-robin among the set bits of core_req; search starts at the rr pointer, and the pointer moves to granted index+1 mod NUM_CORES.
REQ-025 The grant SHALL be registered: core_grant, core_base and core_len are valid in the cycle after the request is sampled, and core_base/core_len hold until the next grant.
REQ-026 On the grant cycle, SHALL exclude from arbitration the core granted in the previous cycle; the core shall drop core_req within 1 cycle of its grant.
REQ-027 core_len SHALL be min(2^CHUNK_LOG2, last-next+1), computed in 33-bit arithmetic; next then advances by core_len.
REQ-028 The final chunk SHALL be truncated at last, with no wrap past 0xFFFFFFFF; when last=0xFFFFFFFF, exhaustion is detected by the 33-bit carry.
REQ-029 When the range is exhausted (the last chunk has been granted), SHALL go to DRAIN.
REQ-030 In any busy state, any core_found bit SHALL latch found=1, found_nonce and found_core, and move DISPATCH to DRAIN; grants stop in the same cycle the hit is sampled.
REQ-031 Simultaneous core_found bits SHALL be resolved to the lowest index; any hit after the first latch SHALL be ignored.
REQ-032 cfg_stop in DISPATCH SHALL move to DRAIN; cfg_stop in DRAIN, IDLE or DONE SHALL have no effect.
REQ-033 DRAIN SHALL issue no grants; it SHALL go to DONE in the first cycle in which core_busy==0 and no core_grant was issued in the previous cycle.
REQ-034 DONE SHALL hold done, found, found_nonce and found_core until the next accepted cfg_start; irq SHALL pulse for exactly 1 cycle on entry to DONE.
REQ-035 A cfg_start and a core_found in the same cycle in DONE SHALL take the start and discard the hit.

Reset
REQ-036 On wb_rst=1 at a clock edge, the state SHALL become IDLE and every output SHALL be 0, including core_grant, core_base, core_len, found_nonce and found_core; the rr pointer SHALL reset to 0.
REQ-037 wb_rst SHALL take effect mid-search at the next edge, and SHALL override cfg_start in the same cycle.

Verification
REQ-038 Bench SHALL cover: lo=0x0, hi=0x3FF, 4 cores always requesting -> 4 grants, bases 0x000/0x100/0x200/0x300, each core_len=256, granted to cores 0,1,2,3 in order, then done=1, found=0, irq pulses once.
REQ-039 Bench SHALL cover: lo=0xFFFFFF80, hi=0xFFFFFFFF -> a single grant with base 0xFFFFFF80 and core_len=128, then DONE with no wrap to 0.
REQ-040 Bench SHALL cover: core_found on cores 1 and 3 in the same cycle with nonces 0xAAAA and 0xBBBB -> found_nonce=0xAAAA, found_core=1, no further grants, done=1 only after core_busy==0.
REQ-041 Bench SHALL cover: lo=0x10, hi=0x0F -> done=1 one cycle after cfg_start, with zero grants.
REQ-042 Bench SHALL cover: cfg_stop after 2 grants, then cfg_start while draining -> the start is ignored and DONE is reached with found=0.
REQ-043 Bench SHALL cover: wb_rst asserted mid-DISPATCH -> the next cycle shows all outputs 0 and busy=0, and a fresh cfg_start grants core 0 first.

Source files
------------

// File: rtl/btc_nonce_scheduler.sv
// Nonce-range scheduler: splits an inclusive 32-bit nonce range into chunks,
// hands them round-robin to idle hash cores, and latches the first reported hit.
module btc_nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int CHUNK_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      wb_rst,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [31:0]               cfg_nonce_lo,
  input  logic [31:0]               cfg_nonce_hi,
  input  logic [NUM_CORES-1:0]      core_req,
  input  logic [NUM_CORES-1:0]      core_busy,
  input  logic [NUM_CORES-1:0]      core_found,
  input  logic [NUM_CORES*32-1:0]   core_found_nonce,
  output logic [NUM_CORES-1:0]      core_grant,
  output logic [31:0]               core_base,
  output logic [CHUNK_LOG2:0]       core_len,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic [31:0]               found_nonce,
  output logic [2:0]                found_core,
  output logic                      irq
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [32:0] CHUNK = 33'd1 << CHUNK_LOG2;

  state_e                 state_q, state_d;
  logic [32:0]            next_q, next_d;
  logic [31:0]            last_q, last_d;
  logic [2:0]             rr_q, rr_d;
  logic [NUM_CORES-1:0]   grant_q, grant_d;
  logic [31:0]            base_q, base_d;
  logic [CHUNK_LOG2:0]    len_q, len_d;
  logic                   found_q, found_d;
  logic [31:0]            found_nonce_q, found_nonce_d;
  logic [2:0]             found_core_q, found_core_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   irq_q, irq_d;

  logic [7:0]             elig_s;
  logic [3:0]             cand_s;
  logic                   arb_valid_s;
  logic [2:0]             arb_idx_s;
  logic                   hit_any_s;
  logic [2:0]             hit_idx_s;
  logic [31:0]            hit_nonce_s;
  logic                   in_search_s;
  logic                   hit_take_s;
  logic                   start_acc_s;
  logic                   range_bad_s;
  logic                   grant_v_s;
  logic [32:0]            rem_s;
  logic [CHUNK_LOG2:0]    len_s;
  logic                   exhaust_s;

  // Round-robin search from rr_q; the core granted last cycle is masked off.
  always_comb begin
    elig_s      = 8'(core_req & ~grant_q);
    cand_s      = 4'd0;
    arb_valid_s = 1'b0;
    arb_idx_s   = 3'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand_s      = {1'b0, rr_q} + 4'(i);
      cand_s      = (cand_s >= 4'(NUM_CORES)) ? (cand_s - 4'(NUM_CORES)) : cand_s;
      arb_idx_s   = (!arb_valid_s && elig_s[cand_s[2:0]]) ? cand_s[2:0] : arb_idx_s;
      arb_valid_s = arb_valid_s | elig_s[cand_s[2:0]];
    end
  end

  // Lowest-index hit wins: scan downward so the lowest set bit is written last.
  always_comb begin
    hit_any_s   = |core_found;
    hit_idx_s   = 3'd0;
    hit_nonce_s = 32'd0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      hit_idx_s   = core_found[j] ? 3'(j) : hit_idx_s;
      hit_nonce_s = core_found[j] ? core_found_nonce[32*j +: 32] : hit_nonce_s;
    end
  end

  // Chunk sizing in 33 bits so a range ending at 0xFFFFFFFF exhausts via the carry.
  always_comb begin
    rem_s       = {1'b0, last_q} + 33'd1 - next_q;
    len_s       = (rem_s >= CHUNK) ? CHUNK[CHUNK_LOG2:0] : rem_s[CHUNK_LOG2:0];
    exhaust_s   = (rem_s <= CHUNK);
    in_search_s = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    hit_take_s  = in_search_s && hit_any_s && !found_q;
    start_acc_s = cfg_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    range_bad_s = (cfg_nonce_hi < cfg_nonce_lo);
    grant_v_s   = (state_q == S_DISPATCH) && arb_valid_s && !hit_any_s && !cfg_stop;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc_s) begin
          state_d = range_bad_s ? S_DONE : S_DISPATCH;
        end else begin
          state_d = state_q;
        end
      end
      S_DISPATCH: begin
        if (hit_take_s || cfg_stop || (grant_v_s && exhaust_s)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_DRAIN: begin
        if ((core_busy == {NUM_CORES{1'b0}}) && (grant_q == {NUM_CORES{1'b0}})) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    next_d        = next_q;
    last_d        = last_q;
    rr_d          = rr_q;
    grant_d       = {NUM_CORES{1'b0}};
    base_d        = base_q;
    len_d         = len_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_core_d  = found_core_q;
    if (start_acc_s) begin
      next_d        = {1'b0, cfg_nonce_lo};
      last_d        = cfg_nonce_hi;
      found_d       = 1'b0;
      found_nonce_d = 32'd0;
      found_core_d  = 3'd0;
    end else if (grant_v_s) begin
      next_d = next_q + 33'(len_s);
      rr_d   = (({1'b0, arb_idx_s} + 4'd1) >= 4'(NUM_CORES)) ? 3'd0 : (arb_idx_s + 3'd1);
      base_d = next_q[31:0];
      len_d  = len_s;
      for (int k = 0; k < NUM_CORES; k++) begin
        grant_d[k] = (arb_idx_s == 3'(k));
      end
    end else if (hit_take_s) begin
      found_d       = 1'b1;
      found_nonce_d = hit_nonce_s;
      found_core_d  = hit_idx_s;
    end else begin
      next_d = next_q;
    end
    busy_d = (state_d == S_DISPATCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    irq_d  = (state_d == S_DONE) && ((state_q != S_DONE) || start_acc_s);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (wb_rst) begin
      next_q        <= 33'd0;
      last_q        <= 32'd0;
      rr_q          <= 3'd0;
      grant_q       <= {NUM_CORES{1'b0}};
      base_q        <= 32'd0;
      len_q         <= {(CHUNK_LOG2+1){1'b0}};
      found_q       <= 1'b0;
      found_nonce_q <= 32'd0;
      found_core_q  <= 3'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      next_q        <= next_d;
      last_q        <= last_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      base_q        <= base_d;
      len_q         <= len_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_core_q  <= found_core_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      irq_q         <= irq_d;
    end
  end

  assign core_grant  = grant_q;
  assign core_base   = base_q;
  assign core_len    = len_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign found_core  = found_core_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_btc_nonce_scheduler.sv
// Directed bench for btc_nonce_scheduler: expected grants are queued when a
// search is started and compared as the grants appear.
module tb_btc_nonce_scheduler;

  localparam int NC   = 4;
  localparam int CL   = 8;
  localparam int BUSY = 20;

  logic             clk = 1'b0;
  logic             wb_rst;
  logic             cfg_start, cfg_stop;
  logic [31:0]      cfg_nonce_lo, cfg_nonce_hi;
  logic [NC-1:0]    core_req, core_busy, core_found;
  logic [NC*32-1:0] core_found_nonce;
  logic [NC-1:0]    core_grant;
  logic [31:0]      core_base;
  logic [CL:0]      core_len;
  logic             busy, done, found, irq;
  logic [31:0]      found_nonce;
  logic [2:0]       found_core;

  btc_nonce_scheduler #(.NUM_CORES(NC), .CHUNK_LOG2(CL)) dut (
    .clk(clk), .wb_rst(wb_rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_nonce_lo(cfg_nonce_lo), .cfg_nonce_hi(cfg_nonce_hi),
    .core_req(core_req), .core_busy(core_busy), .core_found(core_found),
    .core_found_nonce(core_found_nonce), .core_grant(core_grant),
    .core_base(core_base), .core_len(core_len), .busy(busy), .done(done),
    .found(found), .found_nonce(found_nonce), .found_core(found_core), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [31:0] base;
    int          len;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          grants = 0;
  int          irqs = 0;
  logic        model_on = 1'b0;
  logic        done_prev = 1'b0;
  logic [NC-1:0] busy_at_edge;
  int          busy_cnt [NC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the chunks of [lo,hi] assuming consecutive round-robin cores.
  task automatic push_chunks(input longint unsigned lo, input longint unsigned hi,
                             input int first_core, input int max_n);
    longint unsigned b = lo;
    int k = 0;
    exp_t e;
    while (b <= hi && k < max_n) begin
      e.core = (first_core + k) % NC;
      e.base = b[31:0];
      e.len  = ((hi - b + 1) >= 256) ? 256 : int'(hi - b + 1);
      q.push_back(e);
      b = b + longint'(e.len);
      k++;
    end
  endtask

  // One clock: sample just after the edge, score grants, then drive the core model.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    busy_at_edge = core_busy;
    if (irq) irqs++;
    if (done && !done_prev) check("done_only_when_idle", 64'(busy_at_edge), 64'd0);
    done_prev = done;
    if (core_grant != '0) begin
      grants++;
      if (q.size() == 0) begin
        check("unexpected_grant", 64'(core_grant), 64'd0);
      end else begin
        e = q.pop_front();
        check("grant_core", 64'(core_grant), 64'd1 << e.core);
        check("grant_base", 64'(core_base), 64'(e.base));
        check("grant_len", 64'(core_len), 64'(e.len));
      end
    end
    if (model_on) begin
      for (int i = 0; i < NC; i++) begin
        if (core_grant[i]) busy_cnt[i] = BUSY;
        else if (busy_cnt[i] > 0) busy_cnt[i]--;
        core_busy[i] = (busy_cnt[i] > 0);
        core_req[i]  = (busy_cnt[i] == 0);
      end
    end
  endtask

  task automatic start(input logic [31:0] lo, input logic [31:0] hi);
    grants = 0;
    irqs = 0;
    cfg_nonce_lo = lo;
    cfg_nonce_hi = hi;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int c = 0;
    while (grants < n && c < 100) begin tick(); c++; end
    check("grant_count_reached", 64'(grants), 64'(n));
  endtask

  task automatic wait_done();
    int c = 0;
    while (!done && c < 200) begin tick(); c++; end
    check("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    wb_rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0;
    cfg_nonce_lo = 32'd0; cfg_nonce_hi = 32'd0;
    core_req = '0; core_busy = '0; core_found = '0; core_found_nonce = '0;
    for (int i = 0; i < NC; i++) busy_cnt[i] = 0;
    tick(); tick();
    check("rst_grant", 64'(core_grant), 64'd0);
    check("rst_busy_done", 64'({busy, done, found, irq}), 64'd0);
    check("rst_base_len", 64'({core_base, core_len}), 64'd0);
    wb_rst = 1'b0;
    tick();

    // Four full chunks to cores 0..3, constant requests.
    core_req = 4'hF;
    push_chunks(64'h0, 64'h3FF, 0, 8);
    start(32'h0, 32'h3FF);
    wait_done();
    check("s1_grants", 64'(grants), 64'd4);
    check("s1_found", 64'(found), 64'd0);
    tick(); tick();
    check("s1_irq_once", 64'(irqs), 64'd1);
    check("s1_irq_low", 64'(irq), 64'd0);

    // Top-of-range chunk, no wrap past 0xFFFFFFFF.
    push_chunks(64'hFFFFFF80, 64'hFFFFFFFF, 0, 8);
    start(32'hFFFFFF80, 32'hFFFFFFFF);
    wait_done();
    tick(); tick();
    check("s2_grants", 64'(grants), 64'd1);
    check("s2_base_hold", 64'(core_base), 64'hFFFFFF80);
    check("s2_done_held", 64'(done), 64'd1);

    // Simultaneous hits on cores 1 and 3.
    model_on = 1'b1;
    push_chunks(64'h0, 64'hFFFF, 1, 2);
    start(32'h0, 32'hFFFF);
    wait_grants(2);
    core_found = 4'b1010;
    core_found_nonce[63:32]  = 32'hAAAA;
    core_found_nonce[127:96] = 32'hBBBB;
    tick();
    core_found = '0;
    check("s3_found", 64'(found), 64'd1);
    check("s3_found_nonce", 64'(found_nonce), 64'hAAAA);
    check("s3_found_core", 64'(found_core), 64'd1);
    check("s3_not_done_yet", 64'(done), 64'd0);
    wait_done();
    check("s3_no_more_grants", 64'(grants), 64'd2);
    check("s3_found_held", 64'({found, found_nonce}), {31'd0, 1'b1, 32'hAAAA});

    // Inverted range finishes immediately.
    start(32'h10, 32'h0F);
    check("s4_done_next", 64'(done), 64'd1);
    check("s4_found_cleared", 64'({found, found_nonce, found_core}), 64'd0);
    check("s4_busy", 64'(busy), 64'd0);
    check("s4_irq", 64'(irq), 64'd1);
    tick();
    check("s4_no_grants", 64'(grants), 64'd0);

    // Stop after two grants, then an ignored start while draining.
    push_chunks(64'h0, 64'hFFFF, 3, 2);
    start(32'h0, 32'hFFFF);
    wait_grants(2);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    cfg_nonce_lo = 32'h0; cfg_nonce_hi = 32'hF;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("s5_draining", 64'({busy, done}), 64'b10);
    check("s5_base_hold", 64'(core_base), 64'h100);
    wait_done();
    check("s5_grants", 64'(grants), 64'd2);
    check("s5_found", 64'(found), 64'd0);

    // Reset mid-dispatch, overriding a simultaneous start.
    model_on = 1'b0;
    core_req = 4'hF; core_busy = '0;
    push_chunks(64'h0, 64'hFFFF, 1, 2);
    start(32'h0, 32'hFFFF);
    wait_grants(2);
    wb_rst = 1'b1;
    cfg_nonce_lo = 32'h200; cfg_nonce_hi = 32'h2FF;
    cfg_start = 1'b1;
    tick();
    wb_rst = 1'b0;
    cfg_start = 1'b0;
    check("s6_rst_grant", 64'(core_grant), 64'd0);
    check("s6_rst_flags", 64'({busy, done, found, irq}), 64'd0);
    check("s6_rst_data", 64'({core_base, core_len}), 64'd0);
    check("s6_rst_found", 64'({found_nonce, found_core}), 64'd0);
    tick();
    check("s6_start_overridden", 64'(busy), 64'd0);
    check("s6_queue_drained", 64'(q.size()), 64'd0);
    q.delete();
    push_chunks(64'h200, 64'h2FF, 0, 8);
    start(32'h200, 32'h2FF);
    wait_done();
    check("s6_fresh_grants", 64'(grants), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
